// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory access controller and its arbiter.
package mem_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LD_MAR,
        ST_LD_MDR,
        ST_ACCESS,
        ST_CAPTURE,
        ST_RESP
    } state_t;

    localparam logic PORT_IF = 1'b0;
    localparam logic PORT_D  = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/mem_req_arbiter.sv
// Two-port grant logic for the memory access controller.
// MEM_CTRL_RR_EN defined: round-robin with a last-grant pointer; undefined: data port beats fetch port.
module mem_req_arbiter
    import mem_ctrl_pkg::*;
(
`ifdef MEM_CTRL_RR_EN
    input  logic clk,
    input  logic clr,
    input  logic i_accept,
`endif
    input  logic i_if_req,
    input  logic i_d_req,
    output logic o_grant_valid,
    output logic o_grant_port
);

    assign o_grant_valid = i_if_req | i_d_req;

`ifdef MEM_CTRL_RR_EN
    logic r_last;

    // Reset value makes the data port win the first contested grant.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_last <= PORT_IF;
        end else if (i_accept) begin
            r_last <= o_grant_port;
        end
    end

    always_comb begin
        if (i_if_req && i_d_req) begin
            o_grant_port = ~r_last;
        end else begin
            o_grant_port = i_d_req ? PORT_D : PORT_IF;
        end
    end
`else
    assign o_grant_port = i_d_req ? PORT_D : PORT_IF;
`endif

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequences MAR/MDR/RAM strobes for fetch and data requests and returns read data with a done pulse.
// Optional MEM_CTRL_RR_EN selects round-robin arbitration instead of data-over-fetch priority.
//
// state      | meaning
// ST_IDLE    | no transaction; requests sampled, winner latched
// ST_LD_MAR  | address on bus, MAR loads
// ST_LD_MDR  | store only: write data on bus, MDR loads
// ST_ACCESS  | read or write held for WAIT_CYCLES cycles
// ST_CAPTURE | load only: MDR takes RAM data
// ST_RESP    | done pulse to the granted port
module mem_access_ctrl
    import mem_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 9,
    parameter int DATA_W      = 32,
    parameter int WAIT_CYCLES = 1
) (
    input  logic              clk,
    input  logic              clr,
    input  logic              if_req,
    input  logic [31:0]       if_addr,
    output logic              if_done,
    output logic [DATA_W-1:0] if_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_done,
    output logic [DATA_W-1:0] d_rdata,
    output logic              busy,
    output logic              MAR_enable,
    output logic              MDR_enable,
    output logic              read,
    output logic              write,
    output logic [DATA_W-1:0] bus_out,
    input  logic [DATA_W-1:0] MDR_Data
);

    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WAIT_CYCLES - 1);

    state_t            r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_port, r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;

    logic              w_grant_valid, w_grant_port, w_accept;
    logic              w_txn_port, w_txn_we;
    logic [ADDR_W-1:0] w_txn_addr;
    logic [DATA_W-1:0] w_txn_wdata;

    logic              w_mar_nxt, w_mdr_nxt, w_rd_nxt, w_wr_nxt;
    logic              w_if_done_nxt, w_d_done_nxt, w_busy_nxt;
    logic [DATA_W-1:0] w_bus_nxt;

    logic              w_unused_addr;

    assign w_unused_addr = ^{if_addr[31:ADDR_W], d_addr[31:ADDR_W]};
    assign w_accept      = (r_state == ST_IDLE) && w_grant_valid;

    mem_req_arbiter u_arb (
`ifdef MEM_CTRL_RR_EN
        .clk           (clk),
        .clr           (clr),
        .i_accept      (w_accept),
`endif
        .i_if_req      (if_req),
        .i_d_req       (d_req),
        .o_grant_valid (w_grant_valid),
        .o_grant_port  (w_grant_port)
    );

    // Outputs are registered from the next state, so the entering transaction's
    // attributes must come straight from the winner while still in IDLE.
    always_comb begin
        if (r_state == ST_IDLE) begin
            w_txn_port  = w_grant_port;
            w_txn_we    = (w_grant_port == PORT_D) ? d_we : 1'b0;
            w_txn_addr  = (w_grant_port == PORT_D) ? d_addr[ADDR_W-1:0] : if_addr[ADDR_W-1:0];
            w_txn_wdata = d_wdata;
        end else begin
            w_txn_port  = r_port;
            w_txn_we    = r_we;
            w_txn_addr  = r_addr;
            w_txn_wdata = r_wdata;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE:    if (w_grant_valid) w_state_nxt = ST_LD_MAR;
            ST_LD_MAR:  w_state_nxt = r_we ? ST_LD_MDR : ST_ACCESS;
            ST_LD_MDR:  w_state_nxt = ST_ACCESS;
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = r_we ? ST_RESP : ST_CAPTURE;
                end else begin
                    w_cnt_nxt = r_cnt - CNT_W'(1);
                end
            end
            ST_CAPTURE: w_state_nxt = ST_RESP;
            ST_RESP:    w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
        if (w_state_nxt == ST_ACCESS && r_state != ST_ACCESS) begin
            w_cnt_nxt = CNT_LOAD;
        end

        w_mar_nxt     = 1'b0;
        w_mdr_nxt     = 1'b0;
        w_rd_nxt      = 1'b0;
        w_wr_nxt      = 1'b0;
        w_if_done_nxt = 1'b0;
        w_d_done_nxt  = 1'b0;
        w_bus_nxt     = '0;
        w_busy_nxt    = (w_state_nxt != ST_IDLE);
        case (w_state_nxt)
            ST_LD_MAR: begin
                w_mar_nxt = 1'b1;
                w_bus_nxt = DATA_W'(w_txn_addr);
            end
            ST_LD_MDR: begin
                w_mdr_nxt = 1'b1;
                w_bus_nxt = w_txn_wdata;
            end
            ST_ACCESS: begin
                if (w_txn_we) begin
                    w_wr_nxt  = 1'b1;
                    w_bus_nxt = w_txn_wdata;
                end else begin
                    w_rd_nxt = 1'b1;
                end
            end
            ST_CAPTURE: begin
                w_rd_nxt  = 1'b1;
                w_mdr_nxt = 1'b1;
            end
            ST_RESP: begin
                if (w_txn_port == PORT_D) w_d_done_nxt  = 1'b1;
                else                      w_if_done_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= '0;
            r_port  <= PORT_IF;
            r_we    <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_port  <= w_txn_port;
                r_we    <= w_txn_we;
                r_addr  <= w_txn_addr;
                r_wdata <= w_txn_wdata;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            MAR_enable <= 1'b0;
            MDR_enable <= 1'b0;
            read       <= 1'b0;
            write      <= 1'b0;
            bus_out    <= '0;
            if_done    <= 1'b0;
            d_done     <= 1'b0;
            busy       <= 1'b0;
        end else begin
            MAR_enable <= w_mar_nxt;
            MDR_enable <= w_mdr_nxt;
            read       <= w_rd_nxt;
            write      <= w_wr_nxt;
            bus_out    <= w_bus_nxt;
            if_done    <= w_if_done_nxt;
            d_done     <= w_d_done_nxt;
            busy       <= w_busy_nxt;
        end
    end

    // MDR_Data carries RAM data during CAPTURE, so rdata is valid alongside done.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            if_rdata <= '0;
            d_rdata  <= '0;
        end else if (r_state == ST_CAPTURE && w_state_nxt == ST_RESP) begin
            if (r_port == PORT_D) d_rdata  <= MDR_Data;
            else                  if_rdata <= MDR_Data;
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scoreboard bench for mem_access_ctrl: a datapath model answers the strobes, a monitor checks each done.
module tb_mem_access_ctrl;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp;
    } item_t;

    typedef struct {
        logic port;
        int   cyc;
    } log_t;

    logic        clk = 1'b0;
    logic        clr = 1'b1;
    logic        if_req = 1'b0, d_req = 1'b0, d_we = 1'b0;
    logic [31:0] if_addr = '0, d_addr = '0, d_wdata = '0;
    logic        if_done, d_done, busy, MAR_enable, MDR_enable, read, write;
    logic [31:0] if_rdata, d_rdata, bus_out, MDR_Data;

    logic        if_req3 = 1'b0, d_req3 = 1'b0, d_we3 = 1'b0;
    logic [31:0] if_addr3 = '0, d_addr3 = '0, d_wdata3 = '0;
    logic        if_done3, d_done3, busy3, mar3, mdr3, read3, write3;
    logic [31:0] if_rdata3, d_rdata3, bus3, MDR_Data3;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int start_cyc = 0;
    logic busy_prev = 1'b0;

    item_t q_d[$], q_if[$], sb_d[$], sb_if[$];
    log_t  done_log[$];

    logic [31:0] ram [512];
    logic [8:0]  mar;
    logic [31:0] mdr;

    always #5 clk = ~clk;

    mem_access_ctrl u_dut (
        .clk(clk), .clr(clr),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .busy(busy),
        .MAR_enable(MAR_enable), .MDR_enable(MDR_enable), .read(read), .write(write),
        .bus_out(bus_out), .MDR_Data(MDR_Data)
    );

    mem_access_ctrl #(.WAIT_CYCLES(3)) u_dut3 (
        .clk(clk), .clr(clr),
        .if_req(if_req3), .if_addr(if_addr3), .if_done(if_done3), .if_rdata(if_rdata3),
        .d_req(d_req3), .d_we(d_we3), .d_addr(d_addr3), .d_wdata(d_wdata3),
        .d_done(d_done3), .d_rdata(d_rdata3), .busy(busy3),
        .MAR_enable(mar3), .MDR_enable(mdr3), .read(read3), .write(write3),
        .bus_out(bus3), .MDR_Data(MDR_Data3)
    );

    // Datapath model: MAR, MDR and a 512-word RAM preloaded with 0xA500_0000 | index.
    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 32'hA500_0000 | 32'(i);
        mar = '0;
        mdr = '0;
    end

    always @(posedge clk) begin
        if (MAR_enable) mar <= bus_out[8:0];
        if (MDR_enable) mdr <= read ? ram[mar] : bus_out;
        if (write)      ram[mar] <= bus_out;
    end

    assign MDR_Data  = (MDR_enable && read) ? ram[mar] : mdr;
    assign MDR_Data3 = (mdr3 && read3) ? 32'h0000_3000 : 32'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic sb_check(input logic port, input logic [31:0] rdata, input int lat);
        item_t e;
        if ((port && sb_d.size() == 0) || (!port && sb_if.size() == 0)) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done port=%0d actual=done required=no_done", port);
            return;
        end
        e = port ? sb_d.pop_front() : sb_if.pop_front();
        chk(port ? "d_latency" : "if_latency", 32'(lat), 32'd3);
        if (!e.we) chk(port ? "d_rdata" : "if_rdata", rdata, e.exp);
    endtask

    initial begin : monitor
        forever begin
            @(negedge clk);
            cyc++;
            if (busy && !busy_prev) start_cyc = cyc;
            busy_prev = busy;
            if (if_done && d_done) begin
                n_checks++;
                n_fail++;
                $display("FAIL dual_done actual=both required=one");
            end else if (d_done) begin
                sb_check(1'b1, d_rdata, cyc - start_cyc);
                done_log.push_back('{port: 1'b1, cyc: cyc});
            end else if (if_done) begin
                sb_check(1'b0, if_rdata, cyc - start_cyc);
                done_log.push_back('{port: 1'b0, cyc: cyc});
            end
        end
    end

    task automatic present_d(input item_t it);
        d_req = 1'b1; d_we = it.we; d_addr = it.addr; d_wdata = it.wdata;
        sb_d.push_back(it);
    endtask

    task automatic present_if(input item_t it);
        if_req = 1'b1; if_addr = it.addr;
        sb_if.push_back(it);
    endtask

    // Requester agents: hold req until done, then either keep it up for the next item or drop it.
    task automatic serve();
        int guard = 0;
        @(negedge clk);
        if (q_d.size() != 0)  present_d(q_d[0]);
        if (q_if.size() != 0) present_if(q_if[0]);
        while ((q_d.size() != 0 || q_if.size() != 0) && guard < 200) begin
            @(negedge clk);
            guard++;
            if (d_done && q_d.size() != 0) begin
                void'(q_d.pop_front());
                @(posedge clk); #1;
                if (q_d.size() != 0) present_d(q_d[0]); else d_req = 1'b0;
            end else if (if_done && q_if.size() != 0) begin
                void'(q_if.pop_front());
                @(posedge clk); #1;
                if (q_if.size() != 0) present_if(q_if[0]); else if_req = 1'b0;
            end
        end
        if (guard >= 200) begin
            n_checks++;
            n_fail++;
            $display("FAIL serve_timeout actual=pending required=complete");
            d_req = 1'b0; if_req = 1'b0;
            q_d.delete(); q_if.delete(); sb_d.delete(); sb_if.delete();
        end
    endtask

    task automatic check_store_seq();
        bit seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) begin seen = 1; break; end
        end
        if (!seen) begin
            n_checks++; n_fail++;
            $display("FAIL seq_start actual=idle required=busy");
            return;
        end
        chk("seq_mar_strobes", {28'h0, MAR_enable, MDR_enable, write, read}, 32'h8);
        chk("seq_mar_bus", bus_out, 32'h0000_0005);
        @(negedge clk);
        chk("seq_mdr_strobes", {28'h0, MAR_enable, MDR_enable, write, read}, 32'h4);
        chk("seq_mdr_bus", bus_out, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("seq_write_strobes", {28'h0, MAR_enable, MDR_enable, write, read}, 32'h2);
        chk("seq_write_bus", bus_out, 32'hDEAD_BEEF);
        @(negedge clk);
        chk("seq_d_done", {31'h0, d_done}, 32'h1);
    endtask

    initial begin : main
        logic exp_ord [3];
        bit   seen;
        int   k, run, max_run, done_k;

        repeat (3) @(negedge clk);
        chk("reset_busy_in_clr", {31'h0, busy}, 32'h0);
        clr = 1'b0;
        @(negedge clk);
        chk("reset_strobes", {26'h0, MAR_enable, MDR_enable, read, write, if_done, d_done}, 32'h0);
        chk("reset_busy", {31'h0, busy}, 32'h0);
        chk("reset_bus", bus_out, 32'h0);
        chk("reset_if_rdata", if_rdata, 32'h0);
        chk("reset_d_rdata", d_rdata, 32'h0);
        chk("reset_busy3", {31'h0, busy3}, 32'h0);

        // Store then fetch of the same word.
        q_d.push_back('{we: 1'b1, addr: 32'h0000_0005, wdata: 32'hDEAD_BEEF, exp: 32'h0});
        fork
            serve();
            check_store_seq();
        join
        q_if.push_back('{we: 1'b0, addr: 32'h0000_0005, wdata: 32'h0, exp: 32'hDEAD_BEEF});
        serve();

        // Simultaneous requests; last grant was the fetch port.
`ifdef MEM_CTRL_RR_EN
        exp_ord = '{1'b1, 1'b0, 1'b1};
`else
        exp_ord = '{1'b1, 1'b1, 1'b0};
`endif
        done_log.delete();
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0010, wdata: 32'h0, exp: 32'hA500_0010});
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0011, wdata: 32'h0, exp: 32'hA500_0011});
        q_if.push_back('{we: 1'b0, addr: 32'h0000_0020, wdata: 32'h0, exp: 32'hA500_0020});
        serve();
        chk("arb_grant_count", 32'(done_log.size()), 32'd3);
        if (done_log.size() == 3) begin
            for (int i = 0; i < 3; i++) chk("arb_order", {31'h0, done_log[i].port}, {31'h0, exp_ord[i]});
        end

        // Upper address bits are ignored.
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0205, wdata: 32'h0, exp: 32'hDEAD_BEEF});
        serve();

        // A store leaves d_rdata untouched.
        q_d.push_back('{we: 1'b1, addr: 32'h0000_0030, wdata: 32'h0BAD_F00D, exp: 32'h0});
        serve();
        chk("d_rdata_hold", d_rdata, 32'hDEAD_BEEF);
        q_if.push_back('{we: 1'b0, addr: 32'h0000_0030, wdata: 32'h0, exp: 32'h0BAD_F00D});
        serve();

        // Request held through done restarts right after the IDLE cycle.
        done_log.delete();
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0011, wdata: 32'h0, exp: 32'hA500_0011});
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0011, wdata: 32'h0, exp: 32'hA500_0011});
        serve();
        chk("held_count", 32'(done_log.size()), 32'd2);
        if (done_log.size() == 2) chk("held_gap", 32'(done_log[1].cyc - done_log[0].cyc), 32'd5);

        // Reset during the ACCESS cycle of a store.
        @(negedge clk);
        d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0000_0007; d_wdata = 32'h1234_5678;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy) begin seen = 1; break; end
        end
        chk("clr_txn_started", {31'h0, seen}, 32'h1);
        @(negedge clk);
        @(negedge clk);
        chk("clr_write_before", {31'h0, write}, 32'h1);
        clr = 1'b1;
        d_req = 1'b0;
        #1;
        chk("clr_write_drop", {31'h0, write}, 32'h0);
        chk("clr_busy", {31'h0, busy}, 32'h0);
        chk("clr_d_rdata", d_rdata, 32'h0);
        chk("clr_if_rdata", if_rdata, 32'h0);
        @(negedge clk);
        clr = 1'b0;
        q_d.push_back('{we: 1'b0, addr: 32'h0000_0005, wdata: 32'h0, exp: 32'hDEAD_BEEF});
        serve();

        // WAIT_CYCLES=3 instance.
        @(negedge clk);
        d_req3 = 1'b1; d_addr3 = 32'h0000_0009;
        seen = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (busy3) begin seen = 1; break; end
        end
        chk("w3_started", {31'h0, seen}, 32'h1);
        k = 0; run = 0; max_run = 0; done_k = -1;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            k++;
            if (read3) run++; else run = 0;
            if (run > max_run) max_run = run;
            if (d_done3) begin done_k = k; break; end
        end
        @(posedge clk); #1;
        d_req3 = 1'b0;
        chk("w3_read_run", 32'(max_run), 32'd4);
        chk("w3_done_latency", 32'(done_k), 32'd5);
        chk("w3_rdata", d_rdata3, 32'h0000_3000);

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb_d.size() + sb_if.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1);
    end

endmodule
